// File: rtl/reg_file_wr_arbiter.sv
// reg_file_wr_arbiter
// Shares the single reg_file write port between NREQ requesters using
// round-robin arbitration. A level-sensitive clr_req starts a sweep that
// writes zero to every register, one address per cycle. All wr_* outputs,
// grant_id and clr_busy are registered and drive reg_file directly.
// req_ready is combinational from req_valid and the round-robin pointer.

module reg_file_wr_arbiter #(
  parameter int WIDTH  = 8,
  parameter int LENGTH = 4,
  parameter int NREQ   = 3
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic [NREQ-1:0]                      req_valid,
  input  logic [NREQ*$clog2(LENGTH)-1:0]       req_addr,
  input  logic [NREQ*WIDTH-1:0]                req_data,
  output logic [NREQ-1:0]                      req_ready,
  input  logic                                 clr_req,
  output logic                                 clr_busy,
  output logic                                 wr_en,
  output logic [$clog2(LENGTH)-1:0]            wr_addr,
  output logic [WIDTH-1:0]                     wr_data,
  output logic [$clog2(NREQ)-1:0]              grant_id
);

  localparam int ADDR_WIDTH = $clog2(LENGTH);
  localparam int GW         = $clog2(NREQ);

  typedef enum logic {
    ARB   = 1'b0,
    CLEAR = 1'b1
  } state_t;

  state_t                  state_r;
  state_t                  state_s;
  logic [GW-1:0]           rr_ptr_r;
  logic [GW-1:0]           rr_ptr_s;
  logic [ADDR_WIDTH-1:0]   cnt_r;
  logic [ADDR_WIDTH-1:0]   cnt_s;

  logic                    wr_en_s;
  logic [ADDR_WIDTH-1:0]   wr_addr_s;
  logic [WIDTH-1:0]        wr_data_s;
  logic [GW-1:0]           grant_id_s;
  logic                    clr_busy_s;

  logic                    win_found_s;
  logic [GW-1:0]           win_s;
  logic [GW-1:0]           cand_s;
  logic                    grant_ok_s;

  // Round-robin search: first valid requester starting at rr_ptr, wrapping.
  always_comb begin
    win_found_s = 1'b0;
    win_s       = '0;
    cand_s      = '0;
    for (int k = 0; k < NREQ; k++) begin
      if ((int'(rr_ptr_r) + k) >= NREQ) begin
        cand_s = GW'(int'(rr_ptr_r) + k - NREQ);
      end else begin
        cand_s = GW'(int'(rr_ptr_r) + k);
      end
      if (!win_found_s && req_valid[cand_s]) begin
        win_found_s = 1'b1;
        win_s       = cand_s;
      end else begin
        win_found_s = win_found_s;
      end
    end
  end

  // A grant is only offered in ARB, outside reset, and when no clear is asked for.
  always_comb begin
    grant_ok_s = 1'b0;
    req_ready  = '0;
    if (!rst && (state_r == ARB) && !clr_req && win_found_s) begin
      grant_ok_s        = 1'b1;
      req_ready[win_s]  = 1'b1;
    end else begin
      grant_ok_s = 1'b0;
      req_ready  = '0;
    end
  end

  // Next-state and next-output logic; registered outputs show the current state's write.
  always_comb begin
    state_s    = state_r;
    rr_ptr_s   = rr_ptr_r;
    cnt_s      = cnt_r;
    wr_en_s    = 1'b0;
    wr_addr_s  = '0;
    wr_data_s  = '0;
    grant_id_s = '0;
    clr_busy_s = 1'b0;
    case (state_r)
      ARB: begin
        if (clr_req) begin
          // Enter the sweep; address 0 goes out on the first CLEAR cycle.
          state_s    = CLEAR;
          cnt_s      = '0;
          wr_en_s    = 1'b1;
          clr_busy_s = 1'b1;
        end else if (grant_ok_s) begin
          wr_en_s    = 1'b1;
          wr_addr_s  = req_addr[int'(win_s)*ADDR_WIDTH +: ADDR_WIDTH];
          wr_data_s  = req_data[int'(win_s)*WIDTH +: WIDTH];
          grant_id_s = win_s;
          rr_ptr_s   = (win_s == GW'(NREQ-1)) ? '0 : (win_s + 1'b1);
        end else begin
          wr_en_s = 1'b0;
        end
      end
      CLEAR: begin
        if (cnt_r == ADDR_WIDTH'(LENGTH-1)) begin
          // Last address was on the port this cycle; back to arbitration.
          state_s = ARB;
          cnt_s   = '0;
        end else begin
          cnt_s      = cnt_r + 1'b1;
          wr_en_s    = 1'b1;
          wr_addr_s  = cnt_r + 1'b1;
          clr_busy_s = 1'b1;
        end
      end
      default: begin
        state_s = ARB;
        cnt_s   = '0;
      end
    endcase
  end

  // State, pointer and registered output update with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r  <= ARB;
      rr_ptr_r <= '0;
      cnt_r    <= '0;
      wr_en    <= 1'b0;
      wr_addr  <= '0;
      wr_data  <= '0;
      grant_id <= '0;
      clr_busy <= 1'b0;
    end else begin
      state_r  <= state_s;
      rr_ptr_r <= rr_ptr_s;
      cnt_r    <= cnt_s;
      wr_en    <= wr_en_s;
      wr_addr  <= wr_addr_s;
      wr_data  <= wr_data_s;
      grant_id <= grant_id_s;
      clr_busy <= clr_busy_s;
    end
  end

endmodule

// File: tb/tb_reg_file_wr_arbiter.sv
// tb_reg_file_wr_arbiter
// Directed scenarios followed by randomized traffic. A transaction-level
// model tracks the round-robin pointer and the number of sweep cycles left
// and predicts req_ready each cycle plus the registered write one cycle later.

module tb_reg_file_wr_arbiter;

  localparam int WIDTH  = 8;
  localparam int LENGTH = 4;
  localparam int NREQ   = 3;
  localparam int AW     = $clog2(LENGTH);
  localparam int GW     = $clog2(NREQ);

  logic                   clk = 1'b0;
  logic                   rst;
  logic [NREQ-1:0]        req_valid;
  logic [NREQ*AW-1:0]     req_addr;
  logic [NREQ*WIDTH-1:0]  req_data;
  logic [NREQ-1:0]        req_ready;
  logic                   clr_req;
  logic                   clr_busy;
  logic                   wr_en;
  logic [AW-1:0]          wr_addr;
  logic [WIDTH-1:0]       wr_data;
  logic [GW-1:0]          grant_id;

  int total = 0;
  int bad   = 0;

  // model state
  int   rr         = 0;
  int   sweep_left = 0;
  int   last_win   = -1;
  logic e_en       = 1'b0;
  int   e_addr     = 0;
  int   e_data     = 0;
  int   e_gid      = 0;
  logic e_busy     = 1'b0;

  reg_file_wr_arbiter #(.WIDTH(WIDTH), .LENGTH(LENGTH), .NREQ(NREQ)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_addr  (req_addr),
    .req_data  (req_data),
    .req_ready (req_ready),
    .clr_req   (clr_req),
    .clr_busy  (clr_busy),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .grant_id  (grant_id)
  );

  // free-running clock
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic set_req(input int i, input logic v, input int a, input int d);
    req_valid[i]              = v;
    req_addr[i*AW +: AW]      = AW'(a);
    req_data[i*WIDTH +: WIDTH] = WIDTH'(d);
  endtask

  // One clock cycle: called at negedge with inputs already driven.
  task automatic step();
    int win;
    int idx;
    logic [NREQ-1:0] exp_rdy;
    #1;
    win = -1;
    if (!rst && sweep_left == 0 && !clr_req) begin
      for (int k = 0; k < NREQ; k++) begin
        idx = (rr + k) % NREQ;
        if (win < 0 && req_valid[idx]) win = idx;
      end
    end
    exp_rdy = '0;
    if (win >= 0) exp_rdy[win] = 1'b1;
    check_val("req_ready", 32'(req_ready), 32'(exp_rdy));

    if (rst) begin
      e_en = 1'b0; e_addr = 0; e_data = 0; e_gid = 0; e_busy = 1'b0;
      rr = 0; sweep_left = 0;
    end else if (sweep_left > 0) begin
      sweep_left--;
      if (sweep_left > 0) begin
        e_en = 1'b1; e_addr = LENGTH - sweep_left; e_data = 0; e_gid = 0; e_busy = 1'b1;
      end else begin
        e_en = 1'b0; e_addr = 0; e_data = 0; e_gid = 0; e_busy = 1'b0;
      end
    end else if (clr_req) begin
      sweep_left = LENGTH;
      e_en = 1'b1; e_addr = 0; e_data = 0; e_gid = 0; e_busy = 1'b1;
    end else if (win >= 0) begin
      e_en   = 1'b1;
      e_addr = int'(req_addr[win*AW +: AW]);
      e_data = int'(req_data[win*WIDTH +: WIDTH]);
      e_gid  = win;
      e_busy = 1'b0;
      rr     = (win + 1) % NREQ;
    end else begin
      e_en = 1'b0; e_addr = 0; e_data = 0; e_gid = 0; e_busy = 1'b0;
    end
    last_win = win;

    @(posedge clk);
    #1;
    check_val("wr_en",    32'(wr_en),    32'(e_en));
    check_val("wr_addr",  32'(wr_addr),  32'(e_addr));
    check_val("wr_data",  32'(wr_data),  32'(e_data));
    check_val("grant_id", 32'(grant_id), 32'(e_gid));
    check_val("clr_busy", 32'(clr_busy), 32'(e_busy));
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
  endtask

  initial begin
    rst       = 1'b1;
    clr_req   = 1'b0;
    req_valid = '0;
    req_addr  = '0;
    req_data  = '0;
    @(negedge clk);
    do_reset();
    check_val("rst_wr_en", 32'(wr_en), 32'd0);
    check_val("rst_busy",  32'(clr_busy), 32'd0);

    // single requester write
    set_req(0, 1'b1, 1, 8'hBB);
    step();
    check_val("t1_wr_en",  32'(wr_en),    32'd1);
    check_val("t1_addr",   32'(wr_addr),  32'd1);
    check_val("t1_data",   32'(wr_data),  32'hBB);
    check_val("t1_gid",    32'(grant_id), 32'd0);
    set_req(0, 1'b0, 0, 0);
    step();

    // all three requesting: strict rotation from pointer 0
    do_reset();
    set_req(0, 1'b1, 0, 8'h10);
    set_req(1, 1'b1, 1, 8'h21);
    set_req(2, 1'b1, 2, 8'h32);
    for (int k = 0; k < 6; k++) begin
      step();
      check_val("t2_gid",   32'(grant_id), 32'(k % NREQ));
      check_val("t2_wr_en", 32'(wr_en),    32'd1);
    end
    req_valid = '0;
    step();

    // fill and sweep
    for (int a = 0; a < LENGTH; a++) begin
      set_req(0, 1'b1, a, 8'hAA + a * 8'h11);
      step();
    end
    set_req(0, 1'b0, 0, 0);
    clr_req = 1'b1;
    step();
    clr_req = 1'b0;
    check_val("t3_addr0", 32'(wr_addr),  32'd0);
    check_val("t3_busy0", 32'(clr_busy), 32'd1);
    for (int a = 1; a < LENGTH; a++) begin
      step();
      check_val("t3_addr", 32'(wr_addr),  32'(a));
      check_val("t3_busy", 32'(clr_busy), 32'd1);
    end
    step();
    check_val("t3_end_busy", 32'(clr_busy), 32'd0);
    check_val("t3_end_en",   32'(wr_en),    32'd0);

    // grant then clear next cycle, with req1 still waiting through the sweep
    set_req(1, 1'b1, 2, 8'h5A);
    step();
    check_val("t4_data", 32'(wr_data), 32'h5A);
    clr_req = 1'b1;
    set_req(1, 1'b1, 3, 8'h66);
    step();
    clr_req = 1'b0;
    for (int k = 0; k < LENGTH + 1; k++) step();
    check_val("t5_gid",  32'(grant_id), 32'd1);
    check_val("t5_data", 32'(wr_data),  32'h66);
    set_req(1, 1'b0, 0, 0);
    step();

    // reset in the second sweep cycle
    clr_req = 1'b1;
    step();
    clr_req = 1'b0;
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    check_val("t6_wr_en", 32'(wr_en),    32'd0);
    check_val("t6_busy",  32'(clr_busy), 32'd0);
    step();

    // randomized traffic; held requests stay stable until granted
    for (int n = 0; n < 600; n++) begin
      for (int i = 0; i < NREQ; i++) begin
        if (!req_valid[i] || last_win == i) begin
          set_req(i, ($urandom_range(0, 2) != 0), $urandom_range(0, LENGTH - 1),
                  $urandom_range(0, 255));
        end
      end
      clr_req = ($urandom_range(0, 15) == 0);
      rst     = ($urandom_range(0, 127) == 0);
      step();
    end
    rst = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
